// File: rtl/coin_pkg.sv
// rtl/coin_pkg.sv - shared types, widths and LFSR helper for the coin dispatcher
// Contents:
//   lane_state_e : per-lane state encoding
//   N_LANES_DEF  : default lane count
//   SCORE_W      : score counter width
//   MISS_W       : miss counter width
//   CNT_W        : lane frame-counter width
//   LFSR_TAPS    : feedback mask for the 16-bit Fibonacci LFSR
//   lfsr_next()  : one LFSR step
package coin_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRAVEL,
    CATCH,
    HIT,
    MISS,
    COOL
  } lane_state_e;

  localparam int N_LANES_DEF = 3;
  localparam int SCORE_W     = 16;
  localparam int MISS_W      = 8;
  localparam int CNT_W       = 8;

  // Taps 16,14,13,11 map to bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/coin_dispatcher_if.sv
// rtl/coin_dispatcher_if.sv - per-lane signal bundle between dispatcher and coin sprites
// Signals:
//   o_active      : lane coin active (dispatcher -> coin)
//   o_lane_busy   : lane not idle (dispatcher -> HUD)
//   i_coin_hit    : coin sprite opaque at current pixel (coin -> dispatcher)
//   i_in_position : coin reached its catch position, async (coin -> dispatcher)
// Modports: master = dispatcher side, slave = coin side.
interface coin_dispatcher_if #(
  parameter int N_LANES = 3
);

  logic [N_LANES-1:0] o_active;
  logic [N_LANES-1:0] o_lane_busy;
  logic [N_LANES-1:0] i_coin_hit;
  logic [N_LANES-1:0] i_in_position;

  modport master (
    output o_active,
    output o_lane_busy,
    input  i_coin_hit,
    input  i_in_position
  );

  modport slave (
    input  o_active,
    input  o_lane_busy,
    output i_coin_hit,
    output i_in_position
  );

endinterface

// File: rtl/coin_lane_fsm.sv
// rtl/coin_lane_fsm.sv - one coin lane: launch, travel watchdog, catch window, cooldown
// Ports:
//   clk, rst_n    : pixel clock, async active-low reset
//   frame_tick    : one-cycle pulse per frame
//   spawn         : grant from the arbiter (acted on only in IDLE)
//   in_position   : raw async in_position from the coin
//   collide       : player and this coin opaque at the current pixel
//   active        : lane in TRAVEL or CATCH (combinational)
//   busy          : lane not in IDLE (combinational)
//   hit_evt       : lane in HIT this cycle
//   miss_evt      : lane in MISS this cycle
module coin_lane_fsm
  import coin_pkg::*;
#(
  parameter int TRAVEL_FRAMES   = 64,
  parameter int CATCH_FRAMES    = 20,
  parameter int COOLDOWN_FRAMES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_tick,
  input  logic spawn,
  input  logic in_position,
  input  logic collide,
  output logic active,
  output logic busy,
  output logic hit_evt,
  output logic miss_evt
);

  lane_state_e      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             ip_s1, ip_s2;

  // One counter serves travel, window and cooldown since only one runs per state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      ip_s1 <= 1'b0;
      ip_s2 <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ip_s1 <= in_position;
      ip_s2 <= ip_s1;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (spawn) begin
          state_nxt = TRAVEL;
          cnt_nxt   = CNT_W'(TRAVEL_FRAMES);
        end
      end
      TRAVEL: begin
        if (ip_s2) begin
          state_nxt = CATCH;
          cnt_nxt   = CNT_W'(CATCH_FRAMES);
        end else if (frame_tick) begin
          cnt_nxt = cnt - 1'b1;
          if (cnt == CNT_W'(1)) state_nxt = MISS;
        end
      end
      CATCH: begin
        // Collision is checked first so a hit beats an expiring window.
        if (collide) begin
          state_nxt = HIT;
        end else if (frame_tick) begin
          cnt_nxt = cnt - 1'b1;
          if (cnt == CNT_W'(1)) state_nxt = MISS;
        end
      end
      HIT, MISS: begin
        state_nxt = COOL;
        cnt_nxt   = CNT_W'(COOLDOWN_FRAMES);
      end
      COOL: begin
        if (frame_tick) begin
          cnt_nxt = cnt - 1'b1;
          if (cnt == CNT_W'(1)) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign active   = (state == TRAVEL) || (state == CATCH);
  assign busy     = (state != IDLE);
  assign hit_evt  = (state == HIT);
  assign miss_evt = (state == MISS);

endmodule

// File: rtl/coin_dispatcher.sv
// rtl/coin_dispatcher.sv - launches coin sprites, arbitrates lanes, keeps score and misses
// Ports:
//   i_clk, i_rst_n : pixel clock, async active-low reset
//   i_v_sync       : async frame strobe
//   i_enable       : permits new spawns
//   i_player_hit   : player sprite opaque at current pixel
//   lanes          : per-lane bundle (o_active, o_lane_busy, i_coin_hit, i_in_position)
//   o_score        : catches, saturating
//   o_misses       : misses, saturating
//   o_hit_pulse    : one-cycle pulse on any catch
//   o_miss_pulse   : one-cycle pulse on any miss
module coin_dispatcher
  import coin_pkg::*;
#(
  parameter int          N_LANES         = N_LANES_DEF,
  parameter int          SPAWN_PERIOD    = 90,
  parameter int          CATCH_FRAMES    = 20,
  parameter int          TRAVEL_FRAMES   = 64,
  parameter int          COOLDOWN_FRAMES = 4,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_v_sync,
  input  logic                i_enable,
  input  logic                i_player_hit,
  coin_dispatcher_if.master   lanes,
  output logic [SCORE_W-1:0]  o_score,
  output logic [MISS_W-1:0]   o_misses,
  output logic                o_hit_pulse,
  output logic                o_miss_pulse
);

  localparam int SP_W = $clog2(SPAWN_PERIOD + 1);

  logic               vs_s1, vs_s2, vs_s3;
  logic               frame_tick;
  logic [SP_W-1:0]    spawn_cnt;
  logic [15:0]        lfsr;
  logic               spawn_try;
  logic [1:0]         cand;
  logic [N_LANES-1:0] grant, active_now, busy_now, hit_evt, miss_evt;
  logic [SCORE_W:0]   score_sum;
  logic [MISS_W:0]    miss_sum;
  logic [SCORE_W-1:0] score_q;
  logic [MISS_W-1:0]  misses_q;

  assign frame_tick = vs_s2 & ~vs_s3;
  assign spawn_try  = frame_tick & i_enable & (spawn_cnt == SP_W'(SPAWN_PERIOD - 1));

  // Candidate lane from the LFSR (3 folds onto 1), then first free lane going upward
  // modulo N_LANES. The outer loop runs backwards so the nearest free lane wins.
  always_comb begin
    cand  = (lfsr[1:0] == 2'd3) ? 2'd1 : lfsr[1:0];
    grant = '0;
    if (spawn_try) begin
      for (int k = N_LANES - 1; k >= 0; k--) begin
        for (int l = 0; l < N_LANES; l++) begin
          if (((int'(cand) + k) % N_LANES == l) && !busy_now[l]) begin
            grant    = '0;
            grant[l] = 1'b1;
          end
        end
      end
    end
  end

  for (genvar l = 0; l < N_LANES; l++) begin : g_lane
    coin_lane_fsm #(
      .TRAVEL_FRAMES  (TRAVEL_FRAMES),
      .CATCH_FRAMES   (CATCH_FRAMES),
      .COOLDOWN_FRAMES(COOLDOWN_FRAMES)
    ) u_lane (
      .clk        (i_clk),
      .rst_n      (i_rst_n),
      .frame_tick (frame_tick),
      .spawn      (grant[l]),
      .in_position(lanes.i_in_position[l]),
      .collide    (i_player_hit & lanes.i_coin_hit[l]),
      .active     (active_now[l]),
      .busy       (busy_now[l]),
      .hit_evt    (hit_evt[l]),
      .miss_evt   (miss_evt[l])
    );
  end

  assign score_sum = {1'b0, score_q} + (SCORE_W + 1)'($countones(hit_evt));
  assign miss_sum  = {1'b0, misses_q} + (MISS_W + 1)'($countones(miss_evt));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vs_s1             <= 1'b0;
      vs_s2             <= 1'b0;
      vs_s3             <= 1'b0;
      spawn_cnt         <= '0;
      lfsr              <= LFSR_SEED;
      lanes.o_active    <= '0;
      lanes.o_lane_busy <= '0;
      o_hit_pulse       <= 1'b0;
      o_miss_pulse      <= 1'b0;
      score_q           <= '0;
      misses_q          <= '0;
    end else begin
      vs_s1             <= i_v_sync;
      vs_s2             <= vs_s1;
      vs_s3             <= vs_s2;
      if (frame_tick) begin
        lfsr      <= lfsr_next(lfsr);
        spawn_cnt <= (spawn_cnt == SP_W'(SPAWN_PERIOD - 1)) ? '0 : spawn_cnt + 1'b1;
      end
      lanes.o_active    <= active_now;
      lanes.o_lane_busy <= busy_now;
      o_hit_pulse       <= |hit_evt;
      o_miss_pulse      <= |miss_evt;
      if (|hit_evt)  score_q  <= score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
      if (|miss_evt) misses_q <= miss_sum[MISS_W]   ? '1 : miss_sum[MISS_W-1:0];
    end
  end

  assign o_score  = score_q;
  assign o_misses = misses_q;

endmodule
